usb_fs_rx: RTL
==============

// Module: usb_fs_rx
// PURPOSE
//  Full-speed (12 Mb/s) USB line receiver for the usb_cdc_devices core.
//  - Input: the raw dp/dn pad pair.
//  - Output: decoded bytes with packet framing, for the packet/protocol layer.
//  - Does clock recovery, NRZI decoding, bit unstuffing, SYNC/EOP detection and bus-reset detection.
//  - Mirror of the core's line transmitter that drives dp_tx_o/dn_tx_o.
// PARAMETERS
//  CLK_PER_BIT       4    clk cycles per USB bit (clk = 48 MHz)
//  BUS_RESET_CYCLES  120  continuous SE0 cycles that signal bus reset (2.5 us @ 48 MHz)
// PORTS
//  clk          in   1  single clock, 48 MHz
//  rstn_i       in   1  asynchronous active-low reset
//  dp_rx_i      in   1  USB D+ pad input, asynchronous
//  dn_rx_i      in   1  USB D- pad input, asynchronous
//  rx_en_i      in   1  1 = receive allowed; 0 while the core drives the bus (tx_en_o high)
//  rx_active_o  out  1  high from SYNC accepted until EOP/abort
//  rx_valid_o   out  1  1-cycle pulse: rx_data_o holds a new byte
//  rx_data_o    out  8  received byte, LSB first on the wire; held until next rx_valid_o
//  rx_eop_o     out  1  1-cycle pulse: packet ended with a valid EOP
//  rx_err_o     out  1  1-cycle pulse: stuff error, SE1, or bad EOP
//  bus_reset_o  out  1  level: high while SE0 has lasted >= BUS_RESET_CYCLES
// BEHAVIOUR
//  Reset values
//  - All outputs 0; FSM in IDLE.
//  - Synchronisers reset to J (dp=1, dn=0), so releasing reset never yields a false edge.
//  Input synchronisation
//  - 2-FF synchroniser on each line; this is the line-state latency (2 cycles).
//  - Line states: J = 10, K = 01, SE0 = 00, SE1 = 11.
//  Clock recovery
//  - Phase counter mod CLK_PER_BIT; reloaded to 0 on every J<->K change of the synchronised state.
//  - Sample strobe when counter == CLK_PER_BIT/2, i.e. mid-bit.
//  - Tolerates +/-1 cycle of edge jitter per bit.
//  NRZI decode
//  - Decoded bit = 1 if the sampled state equals the previous sample, 0 on a change.
//  Unstuffing (DATA state only)
//  - Counter of consecutive 1s.
//  - After six 1s, the next bit must be 0 and is discarded.
//  - If that bit is 1: rx_err_o pulse, abort to IDLE, no rx_eop_o.
//  FSM: IDLE -> SYNC -> DATA -> EOP -> IDLE
//  - IDLE: a sampled K moves to SYNC.
//  - SYNC: needs >=4 decoded 0s followed by one 1 (the KK ending the SYNC pattern).
//    - On success: DATA, and rx_active_o rises the next cycle.
//    - SE0/SE1, or more than 8 bits without a match: back to IDLE silently.
//  - DATA: bits shift in LSB first.
//    - On the 8th kept bit: rx_data_o is updated and rx_valid_o pulses the next cycle.
//    - Sampled SE0: go to EOP.
//    - Sampled SE1: rx_err_o pulse, abort.
//  - EOP: requires SE0 for 1-2 bit samples, then J.
//    - If the partial-byte bit count is 0-1, pulse rx_eop_o (a single dribble bit is ignored).
//    - Otherwise pulse rx_err_o.
//    - In both cases go to IDLE; rx_active_o falls the same cycle as the pulse.
//    - K after SE0, or SE0 for >2 samples: rx_err_o pulse, then IDLE.
//  Bus reset and abort
//  - An SE0 run counter (in clk cycles) runs in every state.
//  - When it reaches BUS_RESET_CYCLES: bus_reset_o=1, FSM forced to IDLE, no pulses.
//  - bus_reset_o clears on the first non-SE0 synchronised sample.
//  - rx_en_i=0: FSM forced to IDLE next cycle; rx_active_o drops; no valid/eop/err pulses.
//    - The bus-reset detector keeps running.
//  Simultaneous events
//  - rx_valid_o and rx_eop_o never share a cycle.
//  - rx_err_o takes priority over rx_eop_o.
// STRUCTURE
//  - Package usb_rx_pkg:
//    - line_state_t enum {J, K, SE0, SE1}
//    - rx_state_t enum {IDLE, SYNC, DATA, EOP}
//    - STUFF_LIMIT = 6
//  - Sub-module usb_rx_bitclk: synchronisers, phase counter, sample strobe, NRZI decode.
//    - Outputs: bit_strobe, bit_val, line_state.
//  - Top level: FSM, unstuffing, shift register, SE0 timer.
// TESTING
//  1. SYNC, byte 0xA5, SE0 x2 bits, J -> one rx_valid_o with 0xA5; one rx_eop_o;
//     rx_active_o high throughout the packet; no rx_err_o.
//  2. Bytes 0xFF,0xFF with stuff bits inserted -> rx_data_o 0xFF twice; no rx_err_o.
//  3. Seven consecutive 1s after SYNC -> rx_err_o pulse; rx_active_o low; no rx_eop_o.
//  4. SE0 held 130 cycles, then J -> bus_reset_o rises at cycle 122 (120 + 2 sync),
//     falls 2 cycles after J.
//  5. rx_en_i dropped mid-byte -> rx_active_o low next cycle; no valid/eop/err pulses.
//  6. Bit period alternating 3/5 cycles on byte 0x3C -> rx_data_o 0x3C; no error.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared types and constants for the full-speed USB line receiver.
//   line_state_t : synchronised pad-pair state, encoded as {dp, dn}
//   rx_state_t   : receiver framing state
//   STUFF_LIMIT  : run of decoded 1s after which a stuffed 0 is expected
package usb_rx_pkg;

  typedef enum logic [1:0] {
    SE0 = 2'b00,
    K   = 2'b01,
    J   = 2'b10,
    SE1 = 2'b11
  } line_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    EOP
  } rx_state_t;

  localparam int STUFF_LIMIT = 6;

endpackage

// File: rtl/usb_rx_bitclk.sv
// usb_rx_bitclk: pad synchronisers, bit clock recovery and NRZI decode.
//   clk        in   48 MHz clock
//   rstn_i     in   asynchronous active-low reset
//   dp_rx_i    in   raw D+ pad (asynchronous)
//   dn_rx_i    in   raw D- pad (asynchronous)
//   bit_strobe out  one cycle per bit, at mid-bit
//   bit_val    out  NRZI-decoded bit, valid with bit_strobe
//   line_state out  synchronised line state (every cycle)
module usb_rx_bitclk
  import usb_rx_pkg::*;
#(
  parameter int CLK_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        dp_rx_i,
  input  logic        dn_rx_i,
  output logic        bit_strobe,
  output logic        bit_val,
  output line_state_t line_state
);

  localparam int PH_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

  logic [1:0]      dp_sync;
  logic [1:0]      dn_sync;
  line_state_t     ls_prev;
  line_state_t     sample_prev;
  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_cur;
  logic            jk_edge;

  // Synchronisers come out of reset holding J so no false edge is seen.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      dp_sync <= 2'b11;
      dn_sync <= 2'b00;
    end else begin
      dp_sync <= {dp_sync[0], dp_rx_i};
      dn_sync <= {dn_sync[0], dn_rx_i};
    end
  end

  assign line_state = line_state_t'({dp_sync[1], dn_sync[1]});

  // Only J<->K transitions carry timing; SE0 edges are left free-running.
  assign jk_edge = ((line_state == J) && (ls_prev == K)) ||
                   ((line_state == K) && (ls_prev == J));

  // The edge cycle itself is phase 0, so the strobe lands mid-bit.
  assign phase_cur  = jk_edge ? '0 : phase_q;
  assign bit_strobe = (phase_cur == PH_W'(CLK_PER_BIT / 2));
  assign bit_val    = (line_state == sample_prev);

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      ls_prev     <= J;
      sample_prev <= J;
      phase_q     <= '0;
    end else begin
      ls_prev <= line_state;
      phase_q <= (phase_cur == PH_W'(CLK_PER_BIT - 1)) ? '0 : phase_cur + PH_W'(1);
      if (bit_strobe) sample_prev <= line_state;
    end
  end

endmodule

// File: rtl/usb_fs_rx.sv
// usb_fs_rx: full-speed USB line receiver (framing, unstuffing, bus reset).
//   clk          in   48 MHz clock
//   rstn_i       in   asynchronous active-low reset
//   dp_rx_i      in   raw D+ pad
//   dn_rx_i      in   raw D- pad
//   rx_en_i      in   receive allowed (low while transmitting)
//   rx_active_o  out  packet in progress (SYNC accepted until EOP/abort)
//   rx_valid_o   out  1-cycle pulse, rx_data_o holds a new byte
//   rx_data_o    out  last received byte
//   rx_eop_o     out  1-cycle pulse, packet ended with a good EOP
//   rx_err_o     out  1-cycle pulse, stuff error / SE1 / bad EOP
//   bus_reset_o  out  SE0 has lasted at least BUS_RESET_CYCLES
//
// state | meaning
// IDLE  | waiting for the first K of a SYNC
// SYNC  | counting SYNC zeros, waiting for the closing KK
// DATA  | shifting in unstuffed bits, LSB first
// EOP   | SE0 seen, waiting for the closing J
module usb_fs_rx
  import usb_rx_pkg::*;
#(
  parameter int CLK_PER_BIT      = 4,
  parameter int BUS_RESET_CYCLES = 120
) (
  input  logic       clk,
  input  logic       rstn_i,
  input  logic       dp_rx_i,
  input  logic       dn_rx_i,
  input  logic       rx_en_i,
  output logic       rx_active_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       rx_eop_o,
  output logic       rx_err_o,
  output logic       bus_reset_o
);

  localparam int SE0_W = $clog2(BUS_RESET_CYCLES + 1);

  line_state_t      line_state;
  logic             bit_strobe;
  logic             bit_val;
  rx_state_t        state, state_next;
  logic [3:0]       bit_cnt, bit_cnt_next;
  logic [2:0]       run_cnt, run_cnt_next;   // SYNC zeros / DATA ones / EOP SE0 samples
  logic [6:0]       shreg, shreg_next;
  logic             byte_done, eop_hit, err_hit;
  logic [SE0_W-1:0] se0_cnt;
  logic             bus_reset;

  usb_rx_bitclk #(.CLK_PER_BIT(CLK_PER_BIT)) u_bitclk (
    .clk        (clk),
    .rstn_i     (rstn_i),
    .dp_rx_i    (dp_rx_i),
    .dn_rx_i    (dn_rx_i),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val),
    .line_state (line_state)
  );

  // Saturating SE0 run timer; the output is gated by the live line state so
  // it drops as soon as a non-SE0 state leaves the synchroniser.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      se0_cnt <= '0;
    end else if (line_state != SE0) begin
      se0_cnt <= '0;
    end else if (se0_cnt != SE0_W'(BUS_RESET_CYCLES)) begin
      se0_cnt <= se0_cnt + SE0_W'(1);
    end
  end

  assign bus_reset   = (line_state == SE0) && (se0_cnt == SE0_W'(BUS_RESET_CYCLES));
  assign bus_reset_o = bus_reset;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      run_cnt    <= '0;
      shreg      <= '0;
      rx_valid_o <= 1'b0;
      rx_eop_o   <= 1'b0;
      rx_err_o   <= 1'b0;
      rx_data_o  <= '0;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      run_cnt    <= run_cnt_next;
      shreg      <= shreg_next;
      rx_valid_o <= byte_done;
      rx_eop_o   <= eop_hit && !err_hit;
      rx_err_o   <= err_hit;
      if (byte_done) rx_data_o <= {bit_val, shreg};
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    run_cnt_next = run_cnt;
    shreg_next   = shreg;
    byte_done    = 1'b0;
    eop_hit      = 1'b0;
    err_hit      = 1'b0;
    if (bus_reset || !rx_en_i) begin
      state_next = IDLE;
    end else if (bit_strobe) begin
      unique case (state)
        IDLE: begin
          // The first K already counts as one SYNC zero.
          if (line_state == K) begin
            state_next   = SYNC;
            bit_cnt_next = 4'd1;
            run_cnt_next = 3'd1;
          end
        end
        SYNC: begin
          if ((line_state == SE0) || (line_state == SE1)) begin
            state_next = IDLE;
          end else if (bit_val && (run_cnt >= 3'd4)) begin
            state_next   = DATA;
            bit_cnt_next = '0;
            run_cnt_next = '0;
          end else if (bit_cnt == 4'd8) begin
            state_next = IDLE;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
            run_cnt_next = bit_val ? 3'd0 :
                           ((run_cnt == 3'd7) ? 3'd7 : run_cnt + 3'd1);
          end
        end
        DATA: begin
          if (line_state == SE1) begin
            err_hit    = 1'b1;
            state_next = IDLE;
          end else if (line_state == SE0) begin
            state_next   = EOP;
            run_cnt_next = 3'd1;
          end else if (run_cnt == 3'(STUFF_LIMIT)) begin
            if (bit_val) begin
              err_hit    = 1'b1;
              state_next = IDLE;
            end else begin
              run_cnt_next = '0;
            end
          end else begin
            shreg_next   = {bit_val, shreg[6:1]};
            run_cnt_next = bit_val ? run_cnt + 3'd1 : 3'd0;
            if (bit_cnt == 4'd7) begin
              byte_done    = 1'b1;
              bit_cnt_next = '0;
            end else begin
              bit_cnt_next = bit_cnt + 4'd1;
            end
          end
        end
        EOP: begin
          if (line_state == SE0) begin
            if (run_cnt == 3'd2) begin
              err_hit    = 1'b1;
              state_next = IDLE;
            end else begin
              run_cnt_next = run_cnt + 3'd1;
            end
          end else if (line_state == J) begin
            state_next = IDLE;
            // A single dribble bit before SE0 is tolerated.
            if (bit_cnt <= 4'd1) eop_hit = 1'b1;
            else                 err_hit = 1'b1;
          end else begin
            err_hit    = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_active_o = (state == DATA) || (state == EOP);
  end

endmodule
